// File: rtl/prog_counter_fetch.sv
// Program counter and fetch sequencer: turns LUT branch targets into
// absolute instruction addresses with bubble, stall, halt and overflow handling.
module prog_counter_fetch #(
  parameter int PC_W    = 10,
  parameter int TGT_W   = 8,
  parameter int BASE_P1 = 0,
  parameter int BASE_P2 = 256,
  parameter int BASE_P3 = 512
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       prog_sel,
  input  logic             stall,
  input  logic             halt,
  input  logic             branch_en,
  input  logic             branch_taken,
  input  logic [TGT_W-1:0] branch_target,
  output logic [PC_W-1:0]  prog_ctr,
  output logic             fetch_valid,
  output logic             done,
  output logic             pc_overflow
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  localparam logic [PC_W-1:0] B1 = PC_W'(BASE_P1);
  localparam logic [PC_W-1:0] B2 = PC_W'(BASE_P2);
  localparam logic [PC_W-1:0] B3 = PC_W'(BASE_P3);
  localparam logic [PC_W-1:0] PC_MAX = '1;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] base_q, base_d;
  logic            fv_q, fv_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;

  logic [PC_W-1:0] sel_base;
  logic [PC_W:0]   sum;
  logic            take;

  always_comb begin
    sel_base = '0;
    unique case (prog_sel)
      2'd1:    sel_base = B1;
      2'd2:    sel_base = B2;
      2'd3:    sel_base = B3;
      default: sel_base = '0;
    endcase
  end

  // Extra carry bit detects a target landing past the top of memory
  assign sum  = {1'b0, base_q}
              + {{(PC_W+1-TGT_W){1'b0}}, branch_target};
  assign take = branch_en && branch_taken;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    base_d  = base_q;
    fv_d    = fv_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start && prog_sel != 2'd0) begin
          base_d  = sel_base;
          pc_d    = sel_base;
          done_d  = 1'b0;
          ovf_d   = 1'b0;
          fv_d    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!stall) begin
          if (halt) begin
            state_d = DONE;
            done_d  = 1'b1;
            fv_d    = 1'b0;
          end else if (take) begin
            if (sum[PC_W]) begin
              state_d = DONE;
              ovf_d   = 1'b1;
              done_d  = 1'b1;
              fv_d    = 1'b0;
            end else begin
              pc_d    = sum[PC_W-1:0];
              state_d = FLUSH;
              fv_d    = 1'b0;
            end
          end else if (pc_q == PC_MAX) begin
            state_d = DONE;
            ovf_d   = 1'b1;
            done_d  = 1'b1;
            fv_d    = 1'b0;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        state_d = RUN;
        fv_d    = 1'b1;
      end
      default: begin
        state_d = IDLE;
        fv_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      base_q  <= '0;
      fv_q    <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      base_q  <= base_d;
      fv_q    <= fv_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign prog_ctr    = pc_q;
  assign fetch_valid = fv_q;
  assign done        = done_q;
  assign pc_overflow = ovf_q;

endmodule

// File: tb/tb_prog_counter_fetch.sv
// Scoreboard bench: two instances (default bases and BASE_P3=900) are
// driven in lockstep and compared against an abstract fetch model.
module tb_prog_counter_fetch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] prog_sel;
  logic       stall, halt, branch_en, branch_taken;
  logic [7:0] branch_target;

  logic [9:0] pc0, pc1;
  logic       fv0, fv1, dn0, dn1, ov0, ov1;

  always #5 clk = ~clk;

  prog_counter_fetch dut0 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .prog_sel(prog_sel), .stall(stall), .halt(halt),
    .branch_en(branch_en), .branch_taken(branch_taken),
    .branch_target(branch_target),
    .prog_ctr(pc0), .fetch_valid(fv0),
    .done(dn0), .pc_overflow(ov0)
  );

  prog_counter_fetch #(.BASE_P3(900)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .prog_sel(prog_sel), .stall(stall), .halt(halt),
    .branch_en(branch_en), .branch_taken(branch_taken),
    .branch_target(branch_target),
    .prog_ctr(pc1), .fetch_valid(fv1),
    .done(dn1), .pc_overflow(ov1)
  );

  typedef struct {
    int k;
    int pc;
    bit fv;
    bit dn;
    bit ov;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // model: mode 0 = stopped (idle/done), 1 = fetching, 2 = bubble
  int m_mode[2], m_pc[2], m_base[2];
  bit m_done[2], m_ovf[2];
  int bases[2][4] = '{'{0, 0, 256, 512}, '{0, 0, 256, 900}};

  task automatic chk(string nm, int k, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0d want %0d", nm, k, act, exp);
    end
  endtask

  function automatic void mreset(int k);
    m_mode[k] = 0;
    m_pc[k]   = 0;
    m_base[k] = 0;
    m_done[k] = 0;
    m_ovf[k]  = 0;
  endfunction

  function automatic void mstep(int k);
    int s;
    if (!rst_n) begin
      mreset(k);
      return;
    end
    case (m_mode[k])
      0: if (start && prog_sel != 0) begin
        m_base[k] = bases[k][prog_sel];
        m_pc[k]   = m_base[k];
        m_done[k] = 0;
        m_ovf[k]  = 0;
        m_mode[k] = 1;
      end
      1: if (!stall) begin
        if (halt) begin
          m_mode[k] = 0;
          m_done[k] = 1;
        end else if (branch_en && branch_taken) begin
          s = m_base[k] + int'(branch_target);
          if (s > 1023) begin
            m_mode[k] = 0;
            m_done[k] = 1;
            m_ovf[k]  = 1;
          end else begin
            m_pc[k]   = s;
            m_mode[k] = 2;
          end
        end else if (m_pc[k] == 1023) begin
          m_mode[k] = 0;
          m_done[k] = 1;
          m_ovf[k]  = 1;
        end else begin
          m_pc[k] = m_pc[k] + 1;
        end
      end
      default: m_mode[k] = 1;
    endcase
  endfunction

  function automatic void push(int k);
    exp_t e;
    e.k  = k;
    e.pc = m_pc[k];
    e.fv = (m_mode[k] == 1);
    e.dn = m_done[k];
    e.ov = m_ovf[k];
    q.push_back(e);
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("prog_ctr", e.k, int'(e.k ? pc1 : pc0), e.pc);
      chk("fetch_valid", e.k, int'(e.k ? fv1 : fv0), int'(e.fv));
      chk("done", e.k, int'(e.k ? dn1 : dn0), int'(e.dn));
      chk("pc_overflow", e.k, int'(e.k ? ov1 : ov0), int'(e.ov));
    end
  end

  task automatic tick();
    mstep(0);
    mstep(1);
    @(posedge clk);
    push(0);
    push(1);
    #1;
  endtask

  task automatic drive(bit st, bit [1:0] ps, bit stl, bit h,
                       bit be, bit bt, bit [7:0] tg);
    start         = st;
    prog_sel      = ps;
    stall         = stl;
    halt          = h;
    branch_en     = be;
    branch_taken  = bt;
    branch_target = tg;
    tick();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  // reset dropped between edges; outputs must clear without a clock
  task automatic async_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_pc", 0, int'(pc0), 0);
    chk("rst_async_fv", 0, int'(fv0), 0);
    chk("rst_async_pc", 1, int'(pc1), 0);
    chk("rst_async_dn", 1, int'(dn1), 0);
    chk("rst_async_ov", 1, int'(ov1), 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    mreset(0);
    mreset(1);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    idle(1);

    // program 2 start, count up
    drive(1, 2, 0, 0, 0, 0, 0);
    idle(3);

    // program 1, taken branch at pc 5
    async_reset();
    drive(1, 1, 0, 0, 0, 0, 0);
    idle(5);
    drive(0, 0, 0, 0, 1, 1, 2);
    idle(3);

    // program 2, not-taken branch at 260 then stalls
    async_reset();
    drive(1, 2, 0, 0, 0, 0, 0);
    idle(4);
    drive(0, 0, 0, 0, 1, 0, 9);
    drive(0, 0, 1, 0, 0, 0, 0);
    drive(1, 3, 1, 0, 1, 1, 7);
    drive(0, 0, 1, 1, 0, 0, 0);
    idle(1);

    // halt beats branch; restart on program 3
    drive(0, 0, 0, 1, 1, 1, 40);
    idle(2);
    drive(1, 3, 0, 0, 0, 0, 0);
    idle(2);

    // base+target overflow (BASE_P3=900 instance)
    drive(0, 0, 0, 0, 1, 1, 200);
    idle(2);

    // run program 3 to the top of memory
    drive(1, 3, 0, 0, 0, 0, 0);
    idle(126);

    // reset mid-run, then start with invalid selector
    async_reset();
    drive(1, 2, 0, 0, 0, 0, 0);
    idle(3);
    async_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    idle(1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) async_reset();
      drive($urandom_range(0, 19) == 0,
            2'($urandom_range(0, 3)),
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 39) == 0,
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 1) == 1,
            8'($urandom));
    end

    @(negedge clk);
    #1;
    chk("queue_drained", 0, q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
